vga_sync_timing: RTL
====================

// Module: vga_sync_timing
// PURPOSE
//  Upstream timing stage of the VGA path. Generates 1-based column/row counters (c1, c2) for the
//  pixel-stage consumer (ROM-addressing/rgb block), plus hsync/vsync delayed to match the consumer's
//  pipeline latency, an active-area flag and frame/line strobes. Default 800x600@60, 40 MHz pixel clock.
// PARAMETERS
//  H_SYNC      128   hsync pulse width, clocks
//  H_BP        88    horizontal back porch
//  H_ACT       800   active pixels per line
//  H_FP        40    horizontal front porch (H_TOTAL = sum = 1056)
//  V_SYNC      4     vsync pulse width, lines
//  V_BP        23    vertical back porch
//  V_ACT       600   active lines
//  V_FP        1     vertical front porch (V_TOTAL = sum = 628)
//  SYNC_DELAY  4     clocks of delay on hsync/vsync/de_d (0..15); matches consumer latency
// PORTS
//  clk          in   1   pixel clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  c1           out  11  column count, 1..H_TOTAL
//  c2           out  11  row count, 1..V_TOTAL
//  de           out  1   active area, aligned with c1/c2 (undelayed)
//  de_d         out  1   de delayed SYNC_DELAY clocks
//  hsync        out  1   negative-polarity hsync, delayed SYNC_DELAY clocks
//  vsync        out  1   negative-polarity vsync, delayed SYNC_DELAY clocks
//  line_start   out  1   1-clock pulse when c1==1
//  frame_start  out  1   1-clock pulse when c1==1 && c2==1
// BEHAVIOUR
//  - Reset: c1<=H_TOTAL, c2<=V_TOTAL (so first post-reset edge wraps both to 1); hsync=vsync=1,
//    de=de_d=0, line_start=frame_start=0; every delay-line stage resets to inactive (1 for syncs, 0 for de).
//  - Reset mid-frame: same values on the next edge; no partial line is completed.
//  - c1: c1==H_TOTAL -> 1, else c1+1. c2 advances only when c1==H_TOTAL: c2==V_TOTAL -> 1, else c2+1.
//    Counter wrap is simultaneous on the last pixel of the last line (c1=1056,c2=628 -> 1,1).
//  - Raw signals, combinational from registered c1/c2:
//    hs_raw = ~(c1 <= H_SYNC); vs_raw = ~(c2 <= V_SYNC);
//    de = (c1 > H_SYNC+H_BP) && (c1 <= H_SYNC+H_BP+H_ACT) && (c2 > V_SYNC+V_BP) && (c2 <= V_SYNC+V_BP+V_ACT).
//    Consumer derives x = c1-(H_SYNC+H_BP)-1, y = c2-(V_SYNC+V_BP)-1 from the same bounds.
//  - Delay line: SYNC_DELAY-stage shift register per signal; SYNC_DELAY=0 -> hsync/vsync/de_d are
//    hs_raw/vs_raw/de directly. Latency from c1/c2 change to hsync change = SYNC_DELAY clocks.
//  - line_start/frame_start registered: asserted in the same cycle c1 (c2) show value 1.
//  - Comparisons done in 12-bit unsigned to avoid overflow of H_TOTAL near 2047.
//  - Pixel gate: no enable; counters advance every clock. No other states; the counters are the FSM.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: adds output `pat_rgb out 3`, 8 vertical colour bars of H_ACT/8 px,
//   bar n = 3'(n) (bar 0 = 000 black .. bar 7 = 111 white), forced 000 when !de, delayed SYNC_DELAY
//   clocks so it aligns with hsync/de_d; usable as rgb source without the ROM stage.
//  Not defined: port absent, no pattern logic; all other behaviour identical.
// TESTING
//  1 rst held 3 clks then released -> first edge c1=1,c2=1, frame_start=1,line_start=1; hsync=1 for 4 clks after.
//  2 run 1 line -> hs_raw low for c1=1..128; hsync low 4 clks later for exactly 128 clks; c1 1056 -> 1, c2 1->2.
//  3 run full frame -> de high 800x600=480000 clks, first at c1=217,c2=28, last at c1=1016,c2=627;
//    frame_start period 663168 clks.
//  4 vsync: low while c2=1..4 (4*1056=4224 clks), delayed 4 clks; c2 628 -> 1 at c1 wrap.
//  5 assert rst at c1=500,c2=300 for 1 clk -> next edge c1=1056,c2=628 state then 1,1; delay stages
//    flushed (hsync=1, de_d=0 for 4 clks).
//  6 VGA_TEST_PATTERN_EN, SYNC_DELAY=0 -> pat_rgb=000 at c1=217, 001 at c1=317, 111 at c1=1016, 000 at c1=1017.

Source files
------------

// File: rtl/vga_sync_timing_if.sv
// Timing bus from vga_sync_timing to the pixel-stage consumer.
// Optional pat_rgb member exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_sync_timing_if;
  // Free-running stream with no valid/ready: the master updates every field on every
  // clock, there is no backpressure, and the slave samples every field on every clock.
  logic [10:0] c1;
  logic [10:0] c2;
  logic        de;
  logic        de_d;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  pat_rgb;
`endif

  modport master (
    output c1, c2, de, de_d, hsync, vsync, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , output pat_rgb
`endif
  );

  modport slave (
    input c1, c2, de, de_d, hsync, vsync, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
    , input pat_rgb
`endif
  );
endinterface

// File: rtl/vga_sync_timing.sv
// VGA timing generator: 1-based column/row counters, delayed negative syncs and active flag.
// Define VGA_TEST_PATTERN_EN to add the 8-bar colour test pattern output (pat_rgb).
module vga_sync_timing #(
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int H_ACT      = 800,
  parameter int H_FP       = 40,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int V_ACT      = 600,
  parameter int V_FP       = 1,
  parameter int SYNC_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst,
  vga_sync_timing_if.master  bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  // 12-bit compare constants keep H_TOTAL near 2047 from overflowing.
  localparam logic [11:0] H_TOT12  = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT12  = 12'(V_TOTAL);
  localparam logic [11:0] H_SYNC12 = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC12 = 12'(V_SYNC);
  localparam logic [11:0] H_DE_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_DE_HI  = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] V_DE_LO  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_DE_HI  = 12'(V_SYNC + V_BP + V_ACT);

  logic [10:0] c1_q, c2_q, c1_n, c2_n;
  logic        ls_q, fs_q;
  logic [11:0] c1_w, c2_w;
  logic        hs_raw, vs_raw, de_raw;

  // The counter pair is the whole state machine: next state here, register below.
  always_comb begin
    c1_n = c1_q + 11'd1;
    c2_n = c2_q;
    if ({1'b0, c1_q} == H_TOT12) begin
      c1_n = 11'd1;
      c2_n = ({1'b0, c2_q} == V_TOT12) ? 11'd1 : c2_q + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= 11'(H_TOTAL);
      c2_q <= 11'(V_TOTAL);
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      c1_q <= c1_n;
      c2_q <= c2_n;
      ls_q <= (c1_n == 11'd1);
      fs_q <= (c1_n == 11'd1) && (c2_n == 11'd1);
    end
  end

  assign c1_w   = {1'b0, c1_q};
  assign c2_w   = {1'b0, c2_q};
  assign hs_raw = ~(c1_w <= H_SYNC12);
  assign vs_raw = ~(c2_w <= V_SYNC12);
  assign de_raw = (c1_w > H_DE_LO) && (c1_w <= H_DE_HI) &&
                  (c2_w > V_DE_LO) && (c2_w <= V_DE_HI);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  logic [11:0] x_w;
  logic [2:0]  bar;
  logic [2:0]  pat_raw;

  // Bar index by threshold compare; anything past the 8th boundary stays in bar 7.
  always_comb begin
    x_w = c1_w - H_DE_LO - 12'd1;
    bar = 3'd0;
    for (int n = 1; n < 8; n++) begin
      if (x_w >= 12'(n * BAR_W)) bar = 3'(n);
    end
    pat_raw = de_raw ? bar : 3'd0;
  end

  localparam int DW = 6;
  localparam logic [DW-1:0] IDLE = 6'b000_011;
  logic [DW-1:0] raw, dly;
  assign raw = {pat_raw, de_raw, vs_raw, hs_raw};
`else
  localparam int DW = 3;
  localparam logic [DW-1:0] IDLE = 3'b011;
  logic [DW-1:0] raw, dly;
  assign raw = {de_raw, vs_raw, hs_raw};
`endif

  // One shared shift register carries every delayed signal so they stay aligned.
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      logic [DW-1:0] stg [SYNC_DELAY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) stg[i] <= IDLE;
        end else begin
          stg[0] <= raw;
          for (int i = 1; i < SYNC_DELAY; i++) stg[i] <= stg[i-1];
        end
      end
      assign dly = stg[SYNC_DELAY-1];
    end
  endgenerate

  assign bus.c1          = c1_q;
  assign bus.c2          = c2_q;
  assign bus.de          = de_raw;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.hsync       = dly[0];
  assign bus.vsync       = dly[1];
  assign bus.de_d        = dly[2];
`ifdef VGA_TEST_PATTERN_EN
  assign bus.pat_rgb     = dly[5:3];
`endif
endmodule
